// File: rtl/axis_data_downsizer.sv
// AXI4-Stream width down-converter: splits each wide beat into narrow words,
// lowest lane first, trimming trailing all-zero keep groups and re-placing tlast.
module axis_data_downsizer #(
  parameter int unsigned IN_WIDTH  = 512,
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast
);

  localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned IN_KW  = IN_WIDTH / 8;
  localparam int unsigned OUT_KW = OUT_WIDTH / 8;

  // Reject width pairs that do not split into a power-of-two number of words.
  if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || (IN_WIDTH != RATIO * OUT_WIDTH))
  begin : g_ratio_check
    $error("axis_data_downsizer: IN_WIDTH/OUT_WIDTH must be a power of two >= 2");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     hi_q;
  logic [IN_WIDTH-1:0]  data_q;
  logic [IN_KW-1:0]     keep_q;
  logic                 last_q;
  logic                 alive_q;

  logic [IDX_W-1:0]     beat_hi;
  logic                 last_word;
  logic                 accept;
  logic                 load;
  logic [OUT_WIDTH-1:0] word_data;
  logic [OUT_KW-1:0]    word_keep;

  // Highest word group of the incoming beat that carries at least one byte.
  always_comb begin
    beat_hi = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (s_axis_tkeep[i*OUT_KW +: OUT_KW] != '0) beat_hi = IDX_W'(i);
    end
  end

  // Select the current word out of the holding register.
  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_data = data_q[i*OUT_WIDTH +: OUT_WIDTH];
        word_keep = keep_q[i*OUT_KW +: OUT_KW];
      end
    end
  end

  // Next-state logic and handshakes; a beat with no bytes and no last is swallowed.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_word     = (state_q == SEND) && (idx_q == hi_q);
    s_axis_tready = alive_q && ((state_q == EMPTY) || (last_word && m_axis_tready));
    accept        = s_axis_tvalid && s_axis_tready;
    load          = accept && !((s_axis_tkeep == '0) && !s_axis_tlast);
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (idx_q != hi_q) begin
            idx_d = IDX_W'(idx_q + 1'b1);
          end else if (load) begin
            idx_d = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, word index and the holding register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      alive_q <= 1'b1;
      if (load) begin
        hi_q   <= beat_hi;
        data_q <= s_axis_tdata;
        keep_q <= s_axis_tkeep;
        last_q <= s_axis_tlast;
      end
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = word_data;
  assign m_axis_tkeep  = word_keep;
  assign m_axis_tlast  = last_q && (idx_q == hi_q) && (state_q == SEND);

endmodule

// File: tb/tb_axis_data_downsizer.sv
// Randomized self-checking bench for axis_data_downsizer against a word-list model.
module tb_axis_data_downsizer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } word_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [511:0] s_data = '0;
  logic [63:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [63:0]  m_data;
  logic [7:0]   m_keep;
  logic         m_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_viol = 0;
  bit p_stall = 0;
  word_t p_word;

  logic [511:0] bd[$];
  logic [63:0]  bk[$];
  logic         bl[$];
  word_t        exp_q[$];
  word_t        obs_q[$];
  int           hs_cyc[$];
  logic         hs_srdy[$];
  int           acc_cyc[$];

  axis_data_downsizer #(.IN_WIDTH(512), .OUT_WIDTH(64)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Observe handshakes and stall stability away from the active edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_valid && s_ready) acc_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        obs_q.push_back({m_data, m_keep, m_last});
        hs_cyc.push_back(cyc);
        hs_srdy.push_back(s_ready);
      end
      if (p_stall && (!m_valid || ({m_data, m_keep, m_last} != p_word))) stall_viol++;
      if (m_valid && !m_ready && s_ready) stall_viol++;
      p_stall = m_valid && !m_ready;
      p_word  = {m_data, m_keep, m_last};
    end else begin
      p_stall = 0;
    end
  end

  // Expected words of one input beat: groups 0..highest-nonzero, tlast on the final one.
  function automatic void add_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int top = -1;
    bd.push_back(d); bk.push_back(k); bl.push_back(l);
    for (int i = 0; i < 8; i++) if (k[i*8 +: 8] != 8'h00) top = i;
    if (top < 0) begin
      if (l) exp_q.push_back({d[63:0], 8'h00, 1'b1});
    end else begin
      for (int i = 0; i <= top; i++) exp_q.push_back({d[i*64 +: 64], k[i*8 +: 8], l && (i == top)});
    end
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_keep();
    logic [63:0] k = '0;
    case ($urandom_range(0, 3))
      0: k = '1;
      1: k = {$urandom, $urandom};
      2: begin
        int n = $urandom_range(0, 64);
        for (int i = 0; i < 64; i++) k[i] = (i < n);
      end
      default: for (int g = 0; g < 8; g++)
        k[g*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    endcase
    return k;
  endfunction

  task automatic clear_model();
    bd.delete(); bk.delete(); bl.delete(); exp_q.delete();
  endtask

  // Stream the queued beats; mode 0 ready high, 1 ready toggling 1,0,.., 2 random.
  task automatic run_stream(input int mode, input int gap);
    int n = 0;
    int budget = 0;
    bit tog = 1;
    bit hold = 0;
    obs_q.delete(); hs_cyc.delete(); hs_srdy.delete(); acc_cyc.delete(); stall_viol = 0;
    while ((n < bd.size() || obs_q.size() < exp_q.size()) && budget < 3000) begin
      if (!hold) begin
        if (n < bd.size() && (gap == 0 || $urandom_range(0, gap) == 0)) begin
          s_valid = 1; s_data = bd[n]; s_keep = bk[n]; s_last = bl[n];
        end else begin
          s_valid = 0;
        end
      end
      case (mode)
        0:       m_ready = 1;
        1:       m_ready = tog;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      @(negedge aclk);
      hold = s_valid && !s_ready;
      if (s_valid && s_ready) n++;
      @(posedge aclk); #1;
      budget++;
    end
    s_valid = 0;
  endtask

  task automatic test_reset();
    s_valid = 1; m_ready = 1; s_keep = '1; s_last = 1; s_data = rand_data();
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({m_valid, s_ready, m_data, m_keep, m_last} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b ready=%b data=%h keep=%h last=%b exp all 0",
               m_valid, s_ready, m_data, m_keep, m_last);
    end
    s_valid = 0;
    #2 aresetn = 1;
    @(posedge aclk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", s_ready, m_valid);
    end
  endtask

  task automatic test_full_beat();
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i);
    clear_model();
    add_beat(d, '1, 1'b1);
    run_stream(0, 0);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL full_count got %0d exp 8", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].d !== 64'h0706050403020100 || obs_q[7].d !== 64'h3F3E3D3C3B3A3938) begin
        errors++; $display("FAIL full_words got w0=%h w7=%h exp 0706050403020100/3F3E3D3C3B3A3938",
                           obs_q[0].d, obs_q[7].d);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL full_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (acc_cyc.size() != 1 || hs_cyc[0] != acc_cyc[0] + 1) begin
        errors++; $display("FAIL full_latency got first word cycle %0d exp %0d", hs_cyc[0],
                           (acc_cyc.size() > 0) ? acc_cyc[0] + 1 : -1);
      end
    end
  endtask

  task automatic test_partial_beat();
    clear_model();
    add_beat(rand_data(), 64'h0FFF, 1'b1);
    run_stream(0, 0);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL partial_count got %0d exp 2", obs_q.size());
    end else begin
      checks++;
      if ({obs_q[0].k, obs_q[0].l, obs_q[1].k, obs_q[1].l} !== {8'hFF, 1'b0, 8'h0F, 1'b1}) begin
        errors++; $display("FAIL partial_keep_last got %h/%b %h/%b exp ff/0 0f/1",
                           obs_q[0].k, obs_q[0].l, obs_q[1].k, obs_q[1].l);
      end
      checks++;
      if (obs_q[0].d !== exp_q[0].d || obs_q[1].d !== exp_q[1].d) begin
        errors++; $display("FAIL partial_data got %h %h exp %h %h",
                           obs_q[0].d, obs_q[1].d, exp_q[0].d, exp_q[1].d);
      end
      checks++;
      if (hs_srdy[1] !== 1'b1 || hs_srdy[0] !== 1'b0) begin
        errors++; $display("FAIL partial_sready got w0=%b w1=%b exp 0 1", hs_srdy[0], hs_srdy[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    add_beat(rand_data(), '1, 1'b0);
    add_beat(rand_data(), '1, 1'b1);
    run_stream(0, 0);
    checks++;
    if (obs_q.size() != 16 || acc_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count got words=%0d accepts=%0d exp 16 2", obs_q.size(), acc_cyc.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (hs_cyc[15] - hs_cyc[0] != 15) begin
        errors++; $display("FAIL b2b_bubble got span %0d exp 15", hs_cyc[15] - hs_cyc[0]);
      end
      checks++;
      if (acc_cyc[1] != hs_cyc[7]) begin
        errors++; $display("FAIL b2b_accept got cycle %0d exp %0d", acc_cyc[1], hs_cyc[7]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_model();
    add_beat(rand_data(), '1, 1'b1);
    run_stream(1, 0);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL bp_count got %0d exp 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || hs_srdy[i] !== (i == 7)) begin
          errors++; $display("FAIL bp_word%0d got %h sready=%b exp %h sready=%b",
                             i, obs_q[i], hs_srdy[i], exp_q[i], (i == 7));
        end
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL bp_stall got %0d violations exp 0", stall_viol);
    end
  endtask

  task automatic test_zero_keep();
    clear_model();
    add_beat(rand_data(), '0, 1'b1);
    add_beat(rand_data(), '0, 1'b0);
    run_stream(0, 0);
    checks++;
    if (obs_q.size() != 1 || acc_cyc.size() != 2) begin
      errors++; $display("FAIL zero_count got words=%0d accepts=%0d exp 1 2", obs_q.size(), acc_cyc.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL zero_word got %h exp %h", obs_q[0], exp_q[0]);
      end
    end
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL zero_drop got ready=%b valid=%b exp 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int b = 0; b < 40; b++) add_beat(rand_data(), rand_keep(), 1'($urandom_range(0, 1)));
    run_stream(2, 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL rand_stall got %0d violations exp 0", stall_viol);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    obs_q.delete(); hs_cyc.delete(); hs_srdy.delete(); acc_cyc.delete();
    s_valid = 1; s_data = rand_data(); s_keep = '1; s_last = 1; m_ready = 1;
    while (hs_cyc.size() < 4 && budget < 50) begin
      @(negedge aclk);
      @(posedge aclk); #1;
      s_valid = 0;
      budget++;
    end
    checks++;
    if (hs_cyc.size() != 4) begin
      errors++; $display("FAIL rstmid_progress got %0d words exp 4", hs_cyc.size());
    end
    aresetn = 0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 64'd0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got valid=%b data=%h ready=%b exp 0 0 0", m_valid, m_data, s_ready);
    end
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got ready=%b valid=%b exp 1 0", s_ready, m_valid);
    end
    clear_model();
    add_beat(rand_data(), '1, 1'b1);
    run_stream(0, 0);
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL rstmid_count got %0d exp 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial_beat();
    test_back_to_back();
    test_backpressure();
    test_zero_keep();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
